cmp_share_arbiter: RTL and testbench

//  Shares one N-bit magnitude comparator among NREQ requesters.

---
 rtl/cmp_arb_pkg.sv | 24 ++
 rtl/comparator_nbit.sv | 25 ++
 rtl/cmp_share_arbiter.sv | 176 +++++++++++++++++
 tb/tb_cmp_share_arbiter.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cmp_arb_pkg.sv
// ---------------------------------------------------------------------------
// cmp_arb_pkg
//   Shared types and helpers for the shared-comparator arbiter.
//   - arb_state_t : sequencer states (idle / compare / respond)
//   - id_width()  : width of a requester index for a given requester count
//   Optional build macro used by the design: CMP_SIGNED_EN (signed compare).
// ---------------------------------------------------------------------------
package cmp_arb_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CMP  = 2'd1,
    S_RESP = 2'd2
  } arb_state_t;

  localparam int DEFAULT_N    = 32;
  localparam int DEFAULT_NREQ = 4;

  // Index width for nreq requesters; never narrower than one bit.
  function automatic int id_width(input int nreq);
    return (nreq > 1) ? $clog2(nreq) : 1;
  endfunction

endpackage

// File: rtl/comparator_nbit.sv
// ---------------------------------------------------------------------------
// comparator_nbit
//   Purely combinational N-bit unsigned magnitude comparator.
//   Ports:
//     a, b     in  N  operands
//     lesser   out 1  a < b
//     greater  out 1  a > b
//     equal    out 1  a == b
//   Exactly one output is high for any operand pair.
// ---------------------------------------------------------------------------
module comparator_nbit #(
  parameter int N = 32
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         lesser,
  output logic         greater,
  output logic         equal
);

  assign lesser  = (a < b);
  assign greater = (a > b);
  assign equal   = (a == b);

endmodule

// File: rtl/cmp_share_arbiter.sv
// ---------------------------------------------------------------------------
// cmp_share_arbiter
//   Shares one N-bit magnitude comparator among NREQ requesters. A
//   round-robin pick accepts one requester's operands, the comparator
//   evaluates them for one cycle, and the result is presented with the
//   requester index until the consumer takes it.
//
//   Ports:
//     clk          in   1       rising-edge clock
//     rst_n        in   1       asynchronous active-low reset
//     req_valid    in   NREQ    per-requester operand valid
//     req_ready    out  NREQ    one-hot accept (combinational, idle only)
//     req_a        in   NREQ*N  operand a, requester i at [i*N +: N]
//     req_b        in   NREQ*N  operand b, requester i at [i*N +: N]
//     rsp_valid    out  1       result valid
//     rsp_ready    in   1       consumer accepts result
//     rsp_id       out  ID_W    requester index of the result
//     rsp_lesser   out  1       a < b
//     rsp_greater  out  1       a > b
//     rsp_equal    out  1       a == b
//
//   Build option:
//     CMP_SIGNED_EN  defined -> operands treated as two's complement by
//                    flipping both MSBs ahead of the unsigned comparator.
//                    Undefined -> plain unsigned compare.
// ---------------------------------------------------------------------------
module cmp_share_arbiter
  import cmp_arb_pkg::*;
#(
  parameter  int N    = DEFAULT_N,
  parameter  int NREQ = DEFAULT_NREQ,
  localparam int ID_W = id_width(NREQ)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ*N-1:0] req_a,
  input  logic [NREQ*N-1:0] req_b,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [ID_W-1:0]   rsp_id,
  output logic              rsp_lesser,
  output logic              rsp_greater,
  output logic              rsp_equal
);

  arb_state_t      state_reg;
  logic [ID_W-1:0] rr_reg;
  logic [ID_W-1:0] id_reg;
  logic [N-1:0]    a_reg;
  logic [N-1:0]    b_reg;

  // Per-requester views of the flat operand buses.
  logic [N-1:0] a_arr [NREQ];
  logic [N-1:0] b_arr [NREQ];

  genvar gi;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_split
      assign a_arr[gi] = req_a[gi*N +: N];
      assign b_arr[gi] = req_b[gi*N +: N];
    end
  endgenerate

  // Round-robin search starting at rr_reg and wrapping at NREQ-1.
  logic            hit_next;
  logic [ID_W-1:0] pick_next;
  logic [ID_W-1:0] idx_next;
  int              idx_full;

  always_comb begin
    hit_next  = 1'b0;
    pick_next = '0;
    idx_next  = '0;
    idx_full  = 0;
    for (int i = 0; i < NREQ; i++) begin
      idx_full = int'(rr_reg) + i;
      if (idx_full >= NREQ) idx_full = idx_full - NREQ;
      idx_next = ID_W'(idx_full);
      if (!hit_next && req_valid[idx_next]) begin
        hit_next  = 1'b1;
        pick_next = idx_next;
      end
    end
  end

  // Accept strobe exists only in IDLE; it is also forced low while reset is
  // asserted so every output reads 0 during reset.
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_ready
      assign req_ready[gi] = rst_n && (state_reg == S_IDLE) && hit_next &&
                             (pick_next == ID_W'(gi));
    end
  endgenerate

  // Comparator inputs. In the signed build, flipping the MSB maps two's
  // complement order onto unsigned order (adds a 2^(N-1) bias to both).
  logic [N-1:0] cmp_a_next;
  logic [N-1:0] cmp_b_next;
  logic         cmp_lesser;
  logic         cmp_greater;
  logic         cmp_equal;

`ifdef CMP_SIGNED_EN
  assign cmp_a_next = {~a_reg[N-1], a_reg[N-2:0]};
  assign cmp_b_next = {~b_reg[N-1], b_reg[N-2:0]};
`else
  assign cmp_a_next = a_reg;
  assign cmp_b_next = b_reg;
`endif

  comparator_nbit #(
    .N (N)
  ) u_cmp (
    .a       (cmp_a_next),
    .b       (cmp_b_next),
    .lesser  (cmp_lesser),
    .greater (cmp_greater),
    .equal   (cmp_equal)
  );

  // Next round-robin start: one past the requester just served.
  logic [ID_W-1:0] rr_next;
  assign rr_next = (id_reg == ID_W'(NREQ - 1)) ? '0 : id_reg + ID_W'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= S_IDLE;
      rr_reg      <= '0;
      id_reg      <= '0;
      a_reg       <= '0;
      b_reg       <= '0;
      rsp_valid   <= 1'b0;
      rsp_id      <= '0;
      rsp_lesser  <= 1'b0;
      rsp_greater <= 1'b0;
      rsp_equal   <= 1'b0;
    end else begin
      case (state_reg)
        S_IDLE: begin
          if (hit_next) begin
            a_reg     <= a_arr[pick_next];
            b_reg     <= b_arr[pick_next];
            id_reg    <= pick_next;
            state_reg <= S_CMP;
          end
        end
        S_CMP: begin
          rsp_valid   <= 1'b1;
          rsp_id      <= id_reg;
          rsp_lesser  <= cmp_lesser;
          rsp_greater <= cmp_greater;
          rsp_equal   <= cmp_equal;
          state_reg   <= S_RESP;
        end
        S_RESP: begin
          // Flags are cleared with rsp_valid so they never linger.
          if (rsp_ready) begin
            rsp_valid   <= 1'b0;
            rsp_id      <= '0;
            rsp_lesser  <= 1'b0;
            rsp_greater <= 1'b0;
            rsp_equal   <= 1'b0;
            rr_reg      <= rr_next;
            state_reg   <= S_IDLE;
          end
        end
        default: begin
          state_reg <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cmp_share_arbiter.sv
// ---------------------------------------------------------------------------
// tb_cmp_share_arbiter
//   Self-checking bench for cmp_share_arbiter (N=32, NREQ=4). A cycle-level
//   reference model (grant from rotating start, result two cycles after
//   grant, held until taken) is checked every cycle; a table of single
//   transactions and hand-written sequences cover the directed cases.
//   Honours CMP_SIGNED_EN for the expected compare result.
// ---------------------------------------------------------------------------
module tb_cmp_share_arbiter;

  localparam int N    = 32;
  localparam int NREQ = 4;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*N-1:0] req_a;
  logic [NREQ*N-1:0] req_b;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [1:0]        rsp_id;
  logic              rsp_lesser;
  logic              rsp_greater;
  logic              rsp_equal;

  always #5 clk = ~clk;

  cmp_share_arbiter #(.N(N), .NREQ(NREQ)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_a       (req_a),
    .req_b       (req_b),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_id      (rsp_id),
    .rsp_lesser  (rsp_lesser),
    .rsp_greater (rsp_greater),
    .rsp_equal   (rsp_equal)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  // Reference model: transaction-level view of the shared comparator.
  bit          m_busy;   // a transaction has been accepted and not yet taken
  bit          m_resp;   // its result is due on the response port
  int          m_rr;     // first requester examined by the next search
  int          m_id;
  logic [31:0] m_a, m_b;

  // Last observed outputs (captured inside step).
  logic [3:0] obs_ready;
  logic       obs_valid;
  logic [2:0] obs_flags;
  logic [1:0] obs_id;

  int acc_ids[$];
  int acc_cyc[$];

  // {lesser, greater, equal} from plain arithmetic.
  function automatic logic [2:0] ref_cmp(input logic [31:0] a, input logic [31:0] b);
`ifdef CMP_SIGNED_EN
    if ($signed(a) < $signed(b)) return 3'b100;
    if ($signed(a) > $signed(b)) return 3'b010;
    return 3'b001;
`else
    if (a < b) return 3'b100;
    if (a > b) return 3'b010;
    return 3'b001;
`endif
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s cyc=%0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic model_reset();
    m_busy = 0;
    m_resp = 0;
    m_rr   = 0;
    m_id   = 0;
    m_a    = '0;
    m_b    = '0;
  endtask

  task automatic set_op(input int i, input logic [31:0] a, input logic [31:0] b);
    req_a[i*N +: N] = a;
    req_b[i*N +: N] = b;
  endtask

  // One clock cycle: called at a falling edge with inputs already driven.
  task automatic step();
    int          pick;
    logic [3:0]  exp_ready;
    logic [2:0]  exp_flags;
    logic [31:0] pa, pb;
    #1;
    pick      = -1;
    exp_ready = '0;
    if (!m_busy) begin
      for (int i = 0; i < NREQ; i++) begin
        int k = (m_rr + i) % NREQ;
        if (pick < 0 && req_valid[k]) pick = k;
      end
    end
    if (pick >= 0) exp_ready[pick] = 1'b1;
    exp_flags = m_resp ? ref_cmp(m_a, m_b) : 3'b000;

    obs_ready = req_ready;
    obs_valid = rsp_valid;
    obs_flags = {rsp_lesser, rsp_greater, rsp_equal};
    obs_id    = rsp_id;

    check("req_ready", 32'(obs_ready), 32'(exp_ready));
    check("rsp_valid", 32'(obs_valid), 32'(m_resp));
    check("rsp_flags", 32'(obs_flags), 32'(exp_flags));
    if (m_resp) check("rsp_id", 32'(obs_id), 32'(m_id));
    if (rsp_valid && rsp_ready) begin
      acc_ids.push_back(int'(rsp_id));
      acc_cyc.push_back(cyc);
    end
    pa = (pick >= 0) ? req_a[pick*N +: N] : '0;
    pb = (pick >= 0) ? req_b[pick*N +: N] : '0;

    @(posedge clk);
    if (m_resp) begin
      if (rsp_ready) begin
        m_resp = 0;
        m_busy = 0;
        m_rr   = (m_id + 1) % NREQ;
      end
    end else if (m_busy) begin
      m_resp = 1;
    end else if (pick >= 0) begin
      m_busy = 1;
      m_id   = pick;
      m_a    = pa;
      m_b    = pb;
    end
    @(negedge clk);
    cyc++;
  endtask

  typedef struct {
    int          id;
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  flags;   // {lesser, greater, equal}
  } vec_t;

  vec_t vecs[8];

  initial begin
    rst_n     = 1'b0;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    rsp_ready = 1'b0;
    model_reset();

    vecs[0] = '{1, 32'd22,         32'd444,        3'b100};
    vecs[1] = '{3, 32'd777,        32'd111,        3'b010};
    vecs[2] = '{0, 32'd8888,       32'd8888,       3'b001};
    vecs[3] = '{2, 32'd5,          32'd6,          3'b100};
`ifdef CMP_SIGNED_EN
    vecs[4] = '{1, 32'hFFFF_FFFF,  32'd1,          3'b100};
    vecs[5] = '{2, 32'd0,          32'hFFFF_FFFF,  3'b010};
    vecs[6] = '{3, 32'h8000_0000,  32'h7FFF_FFFF,  3'b100};
`else
    vecs[4] = '{1, 32'hFFFF_FFFF,  32'd1,          3'b010};
    vecs[5] = '{2, 32'd0,          32'hFFFF_FFFF,  3'b100};
    vecs[6] = '{3, 32'h8000_0000,  32'h7FFF_FFFF,  3'b010};
`endif
    vecs[7] = '{0, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  3'b001};

    @(negedge clk);
    @(negedge clk);
    // Outputs during reset.
    req_valid = 4'b1111;
    #1;
    check("reset_req_ready", 32'(req_ready), 32'h0);
    check("reset_rsp_valid", 32'(rsp_valid), 32'h0);
    check("reset_flags", 32'({rsp_lesser, rsp_greater, rsp_equal}), 32'h0);
    @(negedge clk);
    req_valid = '0;
    rst_n     = 1'b1;
    @(negedge clk);

    // Table of single-requester transactions.
    rsp_ready = 1'b1;
    foreach (vecs[v]) begin
      req_valid = 4'(1 << vecs[v].id);
      set_op(vecs[v].id, vecs[v].a, vecs[v].b);
      step();
      check("vec_grant", 32'(obs_ready), 32'(1 << vecs[v].id));
      req_valid = '0;
      set_op(vecs[v].id, 32'hDEAD_BEEF, 32'h1234_5678);  // only the accept cycle matters
      step();
      check("vec_cmp_cycle_valid", 32'(obs_valid), 32'h0);
      step();
      check("vec_rsp_valid", 32'(obs_valid), 32'h1);
      check("vec_rsp_flags", 32'(obs_flags), 32'(vecs[v].flags));
      check("vec_rsp_id", 32'(obs_id), 32'(vecs[v].id));
      step();
      check("vec_rsp_cleared", 32'(obs_valid), 32'h0);
    end

    // Backpressure on requester 3; others keep requesting.
    req_valid = 4'b1000;
    set_op(3, 32'd777, 32'd111);
    rsp_ready = 1'b0;
    step();
    check("bp_grant", 32'(obs_ready), 32'h8);
    req_valid = 4'b0111;
    step();
    for (int c = 0; c < 5; c++) begin
      step();
      check("bp_valid", 32'(obs_valid), 32'h1);
      check("bp_flags", 32'(obs_flags), 32'(3'b010));
      check("bp_id", 32'(obs_id), 32'h3);
      check("bp_no_grant", 32'(obs_ready), 32'h0);
    end
    rsp_ready = 1'b1;
    step();
    check("bp_accept_no_grant", 32'(obs_ready), 32'h0);
    // Wrap: last served 3, requesters 0 and 2 pending -> 0 wins.
    req_valid = 4'b0101;
    step();
    check("rr_wrap_grant", 32'(obs_ready), 32'h1);
    req_valid = '0;
    step();
    step();
    step();

    // Asynchronous reset while requester 2's result is held.
    req_valid = 4'b0100;
    set_op(2, 32'd9, 32'd3);
    rsp_ready = 1'b0;
    step();
    req_valid = '0;
    step();
    step();
    check("pre_reset_id", 32'(obs_id), 32'h2);
    req_valid = 4'b1111;
    rst_n     = 1'b0;
    #1;
    check("async_rst_valid", 32'(rsp_valid), 32'h0);
    check("async_rst_id", 32'(rsp_id), 32'h0);
    check("async_rst_flags", 32'({rsp_lesser, rsp_greater, rsp_equal}), 32'h0);
    check("async_rst_ready", 32'(req_ready), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();

    // All four requesting continuously with equal operands.
    for (int i = 0; i < NREQ; i++) set_op(i, 32'd8888, 32'd8888);
    rsp_ready = 1'b1;
    acc_ids.delete();
    acc_cyc.delete();
    for (int c = 0; c < 16; c++) step();
    check("rot_count", 32'(acc_ids.size()), 32'd5);
    if (acc_ids.size() >= 5) begin
      for (int j = 0; j < 5; j++) check("rot_id", 32'(acc_ids[j]), 32'(j % NREQ));
      for (int j = 1; j < 5; j++) check("rot_spacing", 32'(acc_cyc[j] - acc_cyc[j-1]), 32'd3);
    end
    req_valid = '0;
    for (int c = 0; c < 4; c++) step();

    // Random traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      req_valid = 4'($urandom_range(0, 15));
      rsp_ready = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < NREQ; i++) begin
        if ($urandom_range(0, 2) == 0)
          set_op(i, 32'($urandom_range(0, 3)), 32'($urandom_range(0, 3)));
        else
          set_op(i, $urandom, $urandom);
      end
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
